// File: rtl/morse_letter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : morse_letter_sequencer
//  Purpose  : Frames a dot/dash symbol stream into letters and word spaces,
//             presenting each letter downstream over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module morse_letter_sequencer #(
  parameter int LETTER_GAP = 6,
  parameter int WORD_GAP   = 14,
  parameter int MAX_SYMS   = 4,
  parameter int GAP_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  button,
  input  logic                  sym_valid,
  input  logic [1:0]            sym_code,
  output logic                  enc_clear,
  output logic [2*MAX_SYMS-1:0] letter_out,
  output logic [2:0]            letter_len,
  output logic                  letter_err,
  output logic                  letter_valid,
  input  logic                  letter_ready,
  output logic                  word_space,
  output logic                  overrun
);

  localparam int         c_ACC_W   = 2 * MAX_SYMS;
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COLLECT = 2'd1;
  localparam logic [1:0] c_EMIT    = 2'd2;

  logic [1:0]         r_state;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [c_ACC_W-1:0] r_acc;
  logic [2:0]         r_count;
  logic               r_err;
  logic               r_arm;
  logic               r_pend;
  logic               r_enc_clear;
  logic [c_ACC_W-1:0] r_letter_out;
  logic [2:0]         r_letter_len;
  logic               r_letter_err;
  logic               r_letter_valid;
  logic               r_word_space;
  logic               r_overrun;

  logic w_letter_gap;
  logic w_word_gap;
  logic w_ws_hit;
  logic w_code_bad;

  assign w_letter_gap = (r_gap_cnt == GAP_W'(LETTER_GAP));
  assign w_word_gap   = (r_gap_cnt == GAP_W'(WORD_GAP));
  // A symbol on the same cycle cancels the word space: it starts a new letter.
  assign w_ws_hit     = r_arm && w_word_gap && !sym_valid;
  assign w_code_bad   = !sym_code[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= c_IDLE;
      r_gap_cnt      <= '0;
      r_acc          <= '0;
      r_count        <= '0;
      r_err          <= 1'b0;
      r_arm          <= 1'b0;
      r_pend         <= 1'b0;
      r_enc_clear    <= 1'b0;
      r_letter_out   <= '0;
      r_letter_len   <= '0;
      r_letter_err   <= 1'b0;
      r_letter_valid <= 1'b0;
      r_word_space   <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_enc_clear  <= 1'b0;
      r_word_space <= 1'b0;

      if (button || sym_valid)
        r_gap_cnt <= '0;
      else if (!w_word_gap)
        r_gap_cnt <= r_gap_cnt + 1'b1;

      if (sym_valid)
        r_arm <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (sym_valid) begin
            r_state <= c_COLLECT;
            r_acc   <= c_ACC_W'(sym_code);
            r_count <= 3'd1;
            r_err   <= w_code_bad;
          end else if (w_ws_hit) begin
            r_word_space <= 1'b1;
            r_arm        <= 1'b0;
          end
        end

        c_COLLECT: begin
          if (sym_valid) begin
            if (r_count == 3'(MAX_SYMS)) begin
              r_err <= 1'b1;
            end else begin
              r_acc   <= {r_acc[c_ACC_W-3:0], sym_code};
              r_count <= r_count + 3'd1;
              if (w_code_bad)
                r_err <= 1'b1;
            end
          end else if (w_letter_gap) begin
            r_state        <= c_EMIT;
            r_letter_out   <= r_acc;
            r_letter_len   <= r_count;
            r_letter_err   <= r_err;
            r_letter_valid <= 1'b1;
            r_enc_clear    <= 1'b1;
            r_arm          <= 1'b1;
          end
        end

        c_EMIT: begin
          if (sym_valid)
            r_overrun <= 1'b1;
          if (letter_ready) begin
            r_state        <= c_IDLE;
            r_letter_valid <= 1'b0;
            r_acc          <= '0;
            r_count        <= '0;
            r_err          <= 1'b0;
            // A word gap seen while holding the letter fires on the first IDLE cycle.
            r_word_space   <= r_pend || w_ws_hit;
            r_pend         <= 1'b0;
            if (w_ws_hit)
              r_arm <= 1'b0;
          end else if (w_ws_hit) begin
            r_pend <= 1'b1;
            r_arm  <= 1'b0;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign enc_clear    = r_enc_clear;
  assign letter_out   = r_letter_out;
  assign letter_len   = r_letter_len;
  assign letter_err   = r_letter_err;
  assign letter_valid = r_letter_valid;
  assign word_space   = r_word_space;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/morse_letter_sequencer.md
Name: morse_letter_sequencer

Overview:
Sits between the button encoder and the character decode/display path, and frames the encoder's symbol stream into letters.
- Accumulates up to 4 dot/dash symbols.
- Detects the inter-letter gap (button idle) and presents the completed letter downstream with a valid/ready handshake.
- Clears the encoder's letter register at each letter boundary.
- Flags a word space after a longer idle gap.

Parameters:
LETTER_GAP, 6, consecutive idle cycles (button low, no symbol) that close a letter.
WORD_GAP, 14, consecutive idle cycles that produce a word space; must be > LETTER_GAP.
MAX_SYMS, 4, maximum symbols per letter; letter_out is 2*MAX_SYMS bits.
GAP_W, 5, gap counter width; must satisfy 2^GAP_W > WORD_GAP.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
button  input  1  synchronized button level, same signal that feeds the encoder
sym_valid  input  1  one-cycle strobe: the encoder has appended one symbol
sym_code  input  2  symbol code qualified by sym_valid: 01 = dot, 11 = dash
enc_clear  output  1  one-cycle active-high pulse that clears the encoder letter register
letter_out  output  2*MAX_SYMS  packed letter, stable while letter_valid is high
letter_len  output  3  symbol count of letter_out, range 1..MAX_SYMS
letter_err  output  1  letter had more than MAX_SYMS symbols or an invalid code; qualified by letter_valid
letter_valid  output  1  letter available downstream
letter_ready  input  1  downstream accepts the letter
word_space  output  1  one-cycle pulse: word gap detected
overrun  output  1  sticky: a symbol arrived while in EMIT and was dropped

Behaviour:
- Reset is sampled only on a clk edge while low. All outputs, the accumulator, the symbol count and gap_cnt go to 0; state goes to IDLE; the word-space arm and pending flags clear. Reset mid-EMIT discards the letter with no handshake.
- gap_cnt:
  - cleared to 0 on any cycle with button=1 or sym_valid=1;
  - otherwise increments each cycle, saturating at WORD_GAP;
  - counts in all states.
- States:
  - IDLE: no symbols held. sym_valid → COLLECT with the accumulator loaded with sym_code and count=1.
  - COLLECT: each sym_valid shifts the accumulator as {acc[2*MAX_SYMS-3:0], sym_code}, so the first symbol lands in the highest occupied pair and the last symbol in bits [1:0]. It also increments count.
    - If count is already MAX_SYMS, the symbol is discarded and the err flag is set.
    - A sym_code of 00 or 10 sets err, and the symbol is still counted.
    - When registered gap_cnt == LETTER_GAP, the next edge enters EMIT. On that edge: letter_out ← acc, letter_len ← count, letter_err ← err, letter_valid ← 1, enc_clear ← 1 for that cycle only, and the word-space arm flag is set.
  - EMIT: letter_out, letter_len and letter_err are held stable.
    - On a cycle with letter_valid && letter_ready, the next edge clears letter_valid and goes to IDLE, with acc, count and err cleared.
    - sym_valid in EMIT drops the symbol and sets overrun.
    - Button activity is allowed and only affects gap_cnt.
- Latency: with no button activity after the last sym_valid (edge t), letter_valid rises at edge t+LETTER_GAP+1.
- Word space:
  - When armed and gap_cnt reaches WORD_GAP:
    - in IDLE: word_space pulses one cycle on the next edge and the arm flag clears;
    - in EMIT: a pending flag is set, and word_space pulses on the first cycle after returning to IDLE.
  - The arm flag clears on any sym_valid, so there is no word space without an intervening letter.
  - Saturation of gap_cnt guarantees at most one word_space per idle period.
- Simultaneous events:
  - sym_valid on the same cycle as gap_cnt == LETTER_GAP: the symbol wins. It is appended, gap_cnt clears and there is no emit.
  - letter_ready high while letter_valid is low is ignored.
- overrun clears only on reset.

Test Plan:
1. Reset low for 2 clocks mid-COLLECT → all outputs 0, state IDLE; after release, a single dot plus idle produces letter_len=1, letter_out=8'h01.
2. Dot, dash, dash (sym_valid 3 cycles apart, button low otherwise), letter_ready tied 1 → letter_valid rises 7 edges after the last strobe, letter_out=8'h1F, letter_len=3, letter_err=0, enc_clear high exactly that cycle, letter_valid low the next cycle.
3. Five dots → letter_len=4, letter_out=8'h55, letter_err=1.
4. Symbol A emitted, letter_ready held 0 for 20 cycles, button idle → letter_valid and letter_out held stable; word_space pulses on the first IDLE cycle after the ready handshake, exactly once.
5. Dot, then letter_ready held low and a dash strobe during EMIT → dash dropped, overrun=1 and stays 1 until reset, emitted letter still 8'h01 with letter_len=1.
6. sym_valid coincident with the gap_cnt==LETTER_GAP cycle → no emit that cycle; the letter is emitted LETTER_GAP+1 edges later with both symbols included.
